// File: rtl/apb_req_master.sv
// -----------------------------------------------------------------------------
// apb_req_master
//
// Bridges a simple valid/ready command/response interface onto an APB master
// port. Only one transaction is in flight at a time: a command is accepted in
// IDLE, driven as a SETUP + ACCESS pair on APB, and its result is held in RESP
// until the response handshake completes.
//
// Optional feature (macro APB_REQ_MASTER_TIMEOUT_EN):
//   When defined, an ACCESS phase stalled by PREADY=0 for TIMEOUT_CYCLES
//   cycles is abandoned and reported as an error response with zero read data.
//   When undefined, ACCESS waits indefinitely and TIMEOUT_CYCLES is unused
//   apart from its range check.
//
// Parameters:
//   APB_ADDR_WIDTH  width of req_addr / PADDR (default 12)
//   TIMEOUT_CYCLES  stall-cycle limit for the optional timeout, 1..65535
//
// Ports:
//   HCLK, HRESETn       clock, synchronous active-low reset
//   req_valid/ready     command handshake
//   req_addr/wdata/write  command payload (byte address, write data, 1=write)
//   rsp_valid/ready     response handshake
//   rsp_rdata/err       response payload (read data or 0, error flag)
//   PADDR..PSLVERR      APB master port
// -----------------------------------------------------------------------------
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]               req_wdata,
  input  logic                      req_write,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  // Reject out-of-range limits at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_req_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
  // Value of the stall counter in the ACCESS cycle that would make it reach
  // the limit; a stall in that cycle ends the access.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`endif

  // All outputs are registers updated together with the state, so each
  // output is a clean function of the state the FSM has just entered.
  // PADDR/PWDATA/PWRITE are loaded straight from the command on acceptance:
  // they serve as the latched copy and keep their last values outside
  // SETUP/ACCESS.
  always_ff @(posedge HCLK) begin
    // NOTE: state is assigned with <= so every register samples the values
    // from before this edge, regardless of statement order.
    if (!HRESETn) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            PADDR     <= req_addr;
            PWDATA    <= req_wdata;
            PWRITE    <= req_write;
            PSEL      <= 1'b1;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end

        ACCESS: begin
          if (PREADY) begin
            rsp_rdata <= PWRITE ? 32'h0 : PRDATA;
            rsp_err   <= PSLVERR;
            rsp_valid <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= RESP;
          end
`ifdef APB_REQ_MASTER_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_cnt == TMO_LAST) begin
              rsp_rdata <= 32'h0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              PSEL      <= 1'b0;
              PENABLE   <= 1'b0;
              state     <= RESP;
            end
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// -----------------------------------------------------------------------------
// tb_apb_req_master
//
// Directed self-checking bench for apb_req_master. Inputs change and outputs
// are sampled 1 time unit after each rising HCLK edge. The timeout scenario
// depends on whether APB_REQ_MASTER_TIMEOUT_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_apb_req_master;

  localparam int AW = 12;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_write;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int n_checks = 0;
  int n_pass   = 0;

  apb_req_master #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_write (req_write),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Checks the APB control pair and both handshake outputs in one go.
  task automatic check_ctl(input string tag, input logic psel, input logic pen,
                           input logic rv, input logic rr);
    check({tag, ".PSEL"},      32'(PSEL),      32'(psel));
    check({tag, ".PENABLE"},   32'(PENABLE),   32'(pen));
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
    check({tag, ".req_ready"}, 32'(req_ready), 32'(rr));
  endtask

  // Issues a command while the master is in IDLE; returns in cycle N+1.
  task automatic issue(input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic write);
    req_addr  = addr;
    req_wdata = wdata;
    req_write = write;
    req_valid = 1'b1;
    check("issue.req_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 1'b0;
  endtask

  // Completes the response handshake from RESP; returns back in IDLE.
  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_ctl({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = 1'b0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // ---- reset state ----
    step();
    step();
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset.PADDR",     32'(PADDR),   32'h0);
    check("reset.PWDATA",    PWDATA,       32'h0);
    check("reset.PWRITE",    32'(PWRITE),  32'h0);
    check("reset.rsp_rdata", rsp_rdata,    32'h0);
    check("reset.rsp_err",   32'(rsp_err), 32'h0);
    HRESETn = 1'b1;
    step();
    check_ctl("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);

    // ---- zero-wait write: PSEL at N+1, PENABLE at N+2, rsp at N+3 ----
    PREADY = 1'b1;
    issue(12'h004, 32'h0000_00A5, 1'b1);
    check_ctl("wr.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    check("wr.PADDR",  32'(PADDR),  32'h004);
    check("wr.PWDATA", PWDATA,      32'h0000_00A5);
    check("wr.PWRITE", 32'(PWRITE), 32'h1);
    step();
    check_ctl("wr.access", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_ctl("wr.resp", 1'b0, 1'b0, 1'b1, 1'b0);
    check("wr.rsp_err",   32'(rsp_err), 32'h0);
    check("wr.rsp_rdata", rsp_rdata,    32'h0);
    check("wr.PADDR_hold", 32'(PADDR),  32'h004);
    handshake("wr");

    // ---- read with 5 wait states: rsp at N+8 ----
    PREADY = 1'b0;
    PRDATA = 32'hFFFF_FFFF;
    issue(12'h01C, 32'h0, 1'b0);
    check_ctl("rd5.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      check_ctl("rd5.wait", 1'b1, 1'b1, 1'b0, 1'b0);
      check("rd5.PADDR", 32'(PADDR), 32'h01C);
      check("rd5.PWRITE", 32'(PWRITE), 32'h0);
      step();
    end
    PREADY = 1'b1;
    PRDATA = 32'h1234_5678;
    check_ctl("rd5.ready", 1'b1, 1'b1, 1'b0, 1'b0);
    check("rd5.PADDR_last", 32'(PADDR), 32'h01C);
    step();
    PRDATA = 32'h0BAD_0BAD;
    check_ctl("rd5.resp", 1'b0, 1'b0, 1'b1, 1'b0);
    check("rd5.rsp_rdata", rsp_rdata,    32'h1234_5678);
    check("rd5.rsp_err",   32'(rsp_err), 32'h0);
    handshake("rd5");

    // ---- slave error, then a clean transaction ----
    PSLVERR = 1'b1;
    PRDATA  = 32'hDEAD_BEEF;
    issue(12'h030, 32'h0, 1'b0);
    step();
    step();
    PSLVERR = 1'b0;
    check_ctl("err.resp", 1'b0, 1'b0, 1'b1, 1'b0);
    check("err.rsp_err",   32'(rsp_err), 32'h1);
    check("err.rsp_rdata", rsp_rdata,    32'hDEAD_BEEF);
    handshake("err");
    issue(12'h040, 32'h5555_AAAA, 1'b1);
    step();
    step();
    check("ok.rsp_err",   32'(rsp_err), 32'h0);
    check("ok.rsp_rdata", rsp_rdata,    32'h0);
    handshake("ok");

    // ---- response back-pressure with req_valid held high ----
    PRDATA = 32'hCAFE_F00D;
    issue(12'h050, 32'h0, 1'b0);
    req_valid = 1'b1;
    req_addr  = 12'h0FF;
    req_write = 1'b1;
    req_wdata = 32'h7777_0000;
    step();
    check_ctl("bp.access", 1'b1, 1'b1, 1'b0, 1'b0);
    check("bp.PADDR", 32'(PADDR), 32'h050);
    step();
    PRDATA = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check_ctl("bp.hold", 1'b0, 1'b0, 1'b1, 1'b0);
      check("bp.rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
      check("bp.PADDR", 32'(PADDR), 32'h050);
      step();
    end
    rsp_ready = 1'b1;
    check_ctl("bp.last", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    rsp_ready = 1'b0;
    check_ctl("bp.idle", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    req_valid = 1'b0;
    check_ctl("bp.next_setup", 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp.next_PADDR",  32'(PADDR),  32'h0FF);
    check("bp.next_PWRITE", 32'(PWRITE), 32'h1);
    step();
    step();
    check_ctl("bp.next_resp", 1'b0, 1'b0, 1'b1, 1'b0);
    handshake("bp");

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    // ---- timeout after 8 stall cycles ----
    PREADY = 1'b0;
    PRDATA = 32'h1111_1111;
    issue(12'h060, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      check_ctl("tmo.stall", 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    check_ctl("tmo.resp", 1'b0, 1'b0, 1'b1, 1'b0);
    check("tmo.rsp_err",   32'(rsp_err), 32'h1);
    check("tmo.rsp_rdata", rsp_rdata,    32'h0);
    handshake("tmo");

    // ---- PREADY arrives in the limit cycle: normal completion ----
    issue(12'h064, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 7; i++) begin
      check_ctl("lim.stall", 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    PREADY = 1'b1;
    PRDATA = 32'hABCD_0123;
    check_ctl("lim.ready", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_ctl("lim.resp", 1'b0, 1'b0, 1'b1, 1'b0);
    check("lim.rsp_err",   32'(rsp_err), 32'h0);
    check("lim.rsp_rdata", rsp_rdata,    32'hABCD_0123);
    handshake("lim");
`else
    // ---- no timeout: ACCESS persists for 1000 stall cycles ----
    PREADY = 1'b0;
    PRDATA = 32'h2222_3333;
    issue(12'h060, 32'h0, 1'b0);
    step();
    repeat (1000) step();
    check_ctl("notmo.still", 1'b1, 1'b1, 1'b0, 1'b0);
    check("notmo.PADDR", 32'(PADDR), 32'h060);
    PREADY = 1'b1;
    step();
    check_ctl("notmo.resp", 1'b0, 1'b0, 1'b1, 1'b0);
    check("notmo.rsp_err",   32'(rsp_err), 32'h0);
    check("notmo.rsp_rdata", rsp_rdata,    32'h2222_3333);
    handshake("notmo");
`endif

    // ---- reset in ACCESS aborts with no response ----
    PREADY = 1'b0;
    PRDATA = 32'h4444_5555;
    issue(12'h070, 32'h0, 1'b0);
    step();
    check_ctl("rst.access", 1'b1, 1'b1, 1'b0, 1'b0);
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    PREADY  = 1'b1;
    check_ctl("rst.after", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst.PADDR", 32'(PADDR), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_ctl("rst.quiet", 1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
